mixer_scheduler: RTL
====================

MIXER_SCHEDULER -- requirements
Module: mixer_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of reference channels sharing one mixer (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 24: audio sample width.
REQ-003 SHALL have parameter SIN_WIDTH, default 18: NCO sine/cosine width.
REQ-004 SHALL have derived CH_W = max(1, clog2(NUM_CH)).
REQ-005 SHALL have port clk  in  1: clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1: reset, synchronous, active-high.
REQ-007 SHALL have port sample_valid  in  1 and sample_data  in  DATA_WIDTH (signed): new audio sample.
REQ-008 SHALL have port sample_ready  out  1: high only in IDLE.
REQ-009 SHALL have port nco_req  out  1 and nco_ch  out  CH_W: sin/cos lookup request for channel nco_ch.
REQ-010 SHALL have port nco_sin  in  SIN_WIDTH and nco_cos  in  SIN_WIDTH (signed): valid exactly one cycle after nco_req.
REQ-011 SHALL have port mix_start  out  1, mix_data  out  DATA_WIDTH, mix_sin  out  SIN_WIDTH, mix_cos  out  SIN_WIDTH: mixer operands.
REQ-012 SHALL have port mix_valid  in  1: mixer o_valid.
REQ-013 SHALL have port res_valid  out  1 and res_ch  out  CH_W: channel tag aligned with mixer output.
REQ-014 SHALL have port frame_done  out  1: one-cycle pulse when all channels for a sample are returned.
REQ-015 SHALL have port overrun  out  1 and err_tag  out  1: sticky flags, cleared by clear_flags  in  1.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-017 IDLE: on sample_valid & sample_ready, SHALL register sample_data, set channel counter to 0, go to RUN.
REQ-018 RUN: SHALL assert nco_req with nco_ch = counter each cycle, increment counter, go to DRAIN after channel NUM_CH-1.
REQ-019 SHALL assert mix_start exactly one cycle after each nco_req, with mix_sin/mix_cos = nco_sin/nco_cos and mix_data = registered sample.
REQ-020 SHALL push the channel index into a tag FIFO (depth NUM_CH) on each mix_start and pop it on each mix_valid.
REQ-021 res_valid SHALL equal mix_valid with non-empty FIFO; res_ch SHALL be the FIFO head in that cycle, combinationally.
REQ-022 SHALL tolerate any mixer latency >= 1 with results in issue order.
REQ-023 SHALL count outstanding operations (+1 mix_start, -1 mix_valid, net 0 when simultaneous).
REQ-024 DRAIN: when outstanding reaches 0 and no mix_start is pending, SHALL pulse frame_done for one cycle and return to IDLE.
REQ-025 sample_valid while not in IDLE SHALL drop the sample and set overrun.
REQ-026 mix_valid with empty tag FIFO SHALL set err_tag, keep res_valid low, and leave the outstanding count at 0.
REQ-027 clear_flags SHALL clear overrun and err_tag; a same-cycle set event SHALL win.
REQ-028 The channel counter SHALL never exceed NUM_CH-1; no wrap-around within a frame.

Reset
REQ-029 Reset SHALL force IDLE, clear counter, outstanding count, tag FIFO, overrun, err_tag, and the sample register.
REQ-030 Reset SHALL hold nco_req, mix_start, res_valid, frame_done low, sample_ready high, and all other outputs at 0.
REQ-031 Reset mid-frame SHALL abort the frame with no further nco_req, mix_start, or frame_done.

Configuration
REQ-032 With macro MIXER_SCHED_CH_MASK_EN defined, SHALL add input ch_enable  NUM_CH, sampled at accept; RUN SHALL skip disabled channels with no bubble cycles.
REQ-033 With MIXER_SCHED_CH_MASK_EN defined and ch_enable = 0, SHALL accept the sample, issue nothing, and pulse frame_done one cycle after accept.
REQ-034 Without MIXER_SCHED_CH_MASK_EN, SHALL service all NUM_CH channels every frame and have no ch_enable port.

Verification
REQ-035 NUM_CH=4, 2-cycle mixer model, sample 0x000100 accepted at edge 0 -> nco_req cycles 1-4 ch 0..3, mix_start cycles 2-5, res_ch 0..3 cycles 4-7, frame_done cycle 8.
REQ-036 sample_valid high at cycle 3 of a frame -> sample dropped, overrun=1; clear_flags -> overrun=0; frame still completes normally.
REQ-037 Reset asserted at cycle 3 of a frame -> IDLE next cycle, sample_ready=1, no frame_done, next sample runs cleanly.
REQ-038 Spurious mix_valid in IDLE -> err_tag=1, res_valid=0.
REQ-039 Mixer latency 5 -> correct res_ch order, frame_done after last result.
REQ-040 MIXER_SCHED_CH_MASK_EN, ch_enable=4'b1010 -> nco_ch 1,3 on consecutive cycles, two results; ch_enable=0 -> frame_done one cycle after accept.

Source files
------------

// File: rtl/mixer_scheduler.sv
// mixer_scheduler: time-shares one sin/cos mixer across NUM_CH reference
// channels. Each accepted sample is paired with every channel's NCO
// output in turn. A tag FIFO puts the channel index back on each result.
// Optional build macro MIXER_SCHED_CH_MASK_EN adds a per-frame channel
// enable mask (ch_enable). Disabled channels are skipped without idle cycles.
module mixer_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 24,
  parameter int SIN_WIDTH  = 18
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] sample_data,
  output logic                         sample_ready,
  output logic                         nco_req,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] nco_ch,
  input  logic signed [SIN_WIDTH-1:0]  nco_sin,
  input  logic signed [SIN_WIDTH-1:0]  nco_cos,
  output logic                         mix_start,
  output logic signed [DATA_WIDTH-1:0] mix_data,
  output logic signed [SIN_WIDTH-1:0]  mix_sin,
  output logic signed [SIN_WIDTH-1:0]  mix_cos,
  input  logic                         mix_valid,
  output logic                         res_valid,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] res_ch,
  output logic                         frame_done,
  input  logic                         clear_flags,
`ifdef MIXER_SCHED_CH_MASK_EN
  input  logic [NUM_CH-1:0]            ch_enable,
`endif
  output logic                         overrun,
  output logic                         err_tag
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OUT_W = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state, state_next;
  logic [CH_W-1:0]         ch;          // channel being requested from the NCO
  logic [CH_W-1:0]         mix_ch_q;    // channel whose operands are on the mixer bus
  logic [DATA_WIDTH-1:0]   sample_q;
  logic                    mix_start_q;
  logic [CH_W-1:0]         tag_mem [NUM_CH];
  logic [CH_W-1:0]         wr_ptr, rd_ptr;
  logic [OUT_W-1:0]        outstanding; // doubles as tag FIFO occupancy
  logic                    accept, push, pop, fifo_empty;
  logic                    last_ch, first_found;
  logic [CH_W-1:0]         ch_first, ch_next;

  assign accept     = sample_valid && (state == IDLE);
  assign fifo_empty = (outstanding == '0);
  assign push       = mix_start_q;
  assign pop        = mix_valid && !fifo_empty;

`ifdef MIXER_SCHED_CH_MASK_EN
  logic [NUM_CH-1:0] mask_q;
  logic              next_found;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [CH_W:0] find_from(input logic [NUM_CH-1:0] m, input int from);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  // Channel sequencing: first enabled channel at accept, then next enabled one.
  always_comb begin
    {first_found, ch_first} = find_from(ch_enable, 0);
    {next_found, ch_next}   = find_from(mask_q, int'(ch) + 1);
    last_ch                 = !next_found;
  end

  // Enable mask is frozen for the whole frame at accept time.
  always_ff @(posedge clk) begin
    if (reset)       mask_q <= '0;
    else if (accept) mask_q <= ch_enable;
  end
`else
  // Channel sequencing: every channel, in order, every frame.
  always_comb begin
    first_found = 1'b1;
    ch_first    = '0;
    ch_next     = ch + 1'b1;
    last_ch     = (ch == CH_W'(NUM_CH - 1));
  end
`endif

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic.
  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (sample_valid) state_next = first_found ? RUN : DRAIN;
      RUN:   if (last_ch) state_next = DRAIN;
      DRAIN: if (fifo_empty && !mix_start_q) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    sample_ready = (state == IDLE);
    nco_req      = (state == RUN);
    frame_done   = (state == DRAIN) && fifo_empty && !mix_start_q;
    nco_ch       = nco_req ? ch : '0;
  end

  // Channel counter, sample register, and the one-cycle NCO-to-mixer alignment.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch          <= '0;
      sample_q    <= '0;
      mix_start_q <= 1'b0;
      mix_ch_q    <= '0;
    end else begin
      if (accept) begin
        ch       <= ch_first;
        sample_q <= sample_data;
      end else if ((state == RUN) && !last_ch) begin
        ch <= ch_next;
      end
      mix_start_q <= nco_req;
      mix_ch_q    <= ch;
    end
  end

  // Mixer operands: NCO data arrives in the mix_start cycle, so it passes straight through.
  always_comb begin
    mix_start = mix_start_q;
    mix_data  = sample_q;
    mix_sin   = mix_start_q ? nco_sin : '0;
    mix_cos   = mix_start_q ? nco_cos : '0;
  end

  // Tag FIFO storage.
  // NOTE: storage is not reset; pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= mix_ch_q;
  end

  // Tag FIFO pointers and outstanding-operation count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == CH_W'(NUM_CH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == CH_W'(NUM_CH - 1)) ? '0 : rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Result tagging: head of FIFO accompanies each mixer result.
  always_comb begin
    res_valid = pop;
    res_ch    = pop ? tag_mem[rd_ptr] : '0;
  end

  // Sticky error flags; a set event in the same cycle beats clear_flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
      err_tag <= 1'b0;
    end else begin
      if (sample_valid && (state != IDLE)) overrun <= 1'b1;
      else if (clear_flags)                overrun <= 1'b0;
      if (mix_valid && fifo_empty)         err_tag <= 1'b1;
      else if (clear_flags)                err_tag <= 1'b0;
    end
  end

endmodule
